// File: rtl/memc_pkg.sv
// Shared memory-controller definitions: frame and search-buffer geometry,
// address widths, the fetch descriptor and the fetch FSM encoding.
package memc_pkg;

   localparam int FRAME_W = 64;
   localparam int FRAME_H = 48;
   localparam int BUF_W   = 12;
   localparam int PIX_W   = 8;

   localparam int MEM_AW  = 12;
   localparam int BUF_AW  = 8;
   localparam int SUM_W   = 7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRAIN,
      ST_DONE
   } fetch_state_e;

   typedef struct packed {
      logic [5:0] blk_row;
      logic [5:0] blk_col;
      logic [3:0] cnt_row;
      logic [3:0] cnt_col;
      logic [3:0] pad_row;
      logic [3:0] pad_col;
   } fetch_desc_t;

   function automatic logic [MEM_AW-1:0] frame_addr(input logic [SUM_W-1:0] row,
                                                    input logic [SUM_W-1:0] col);
      return MEM_AW'(row) * MEM_AW'(FRAME_W) + MEM_AW'(col);
   endfunction

   function automatic logic [BUF_AW-1:0] buf_addr(input logic [BUF_AW-1:0] row,
                                                  input logic [BUF_AW-1:0] col);
      return row * BUF_AW'(BUF_W) + col;
   endfunction

endpackage

// File: rtl/block_fetch_if.sv
// Frame-memory read port and search-buffer write port of the block fetcher.
// The master side is the fetcher; the slave side is memory plus buffer.
interface block_fetch_if;
   import memc_pkg::*;

   logic              mem_req;
   logic [MEM_AW-1:0] mem_addr;
   logic              mem_gnt;
   logic [PIX_W-1:0]  mem_rdata;
   logic              buf_we;
   logic [BUF_AW-1:0] buf_waddr;
   logic [PIX_W-1:0]  buf_wdata;

   modport master (
      output mem_req, mem_addr, buf_we, buf_waddr, buf_wdata,
      input  mem_gnt, mem_rdata
   );

   modport slave (
      input  mem_req, mem_addr, buf_we, buf_waddr, buf_wdata,
      output mem_gnt, mem_rdata
   );

endinterface

// File: rtl/fetch_rd_pipe.sv
// RD_LAT-deep shift register carrying the buffer address of each accepted read
// until its pixel returns from frame memory.
module fetch_rd_pipe
   import memc_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic [BUF_AW-1:0] waddr_i,
   output logic              vld_o,
   output logic [BUF_AW-1:0] waddr_o,
   output logic              pending_o
);

   logic [RD_LAT-1:0] vld_q;
   logic [BUF_AW-1:0] addr_q [RD_LAT];
   logic              pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= push_i;
         for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
      end
   end

   // NOTE: the address stages carry no reset; a stage is only ever observed
   // while its valid bit is set, so resetting them would buy nothing.
   always_ff @(posedge clk) begin
      addr_q[0] <= waddr_i;
      for (int i = 1; i < RD_LAT; i++) addr_q[i] <= addr_q[i-1];
   end

   // Reads still in flight behind the output stage.
   always_comb begin
      pending = 1'b0;
      for (int i = 0; i < RD_LAT - 1; i++) pending = pending | vld_q[i];
   end

   assign pending_o = pending;
   assign vld_o     = vld_q[RD_LAT-1];
   assign waddr_o   = vld_q[RD_LAT-1] ? addr_q[RD_LAT-1] : '0;

endmodule

// File: rtl/block_fetch.sv
// Walks a clipped search-window rectangle of the frame in raster order, reads
// each pixel from frame memory and writes it into the search buffer.
module block_fetch
   import memc_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [5:0]   blk_row,
   input  logic [5:0]   blk_col,
   input  logic [3:0]   cnt_row,
   input  logic [3:0]   cnt_col,
   input  logic [3:0]   pad_row,
   input  logic [3:0]   pad_col,
   output logic         busy,
   output logic         done,
   block_fetch_if.master bus
);

   fetch_state_e      st_q, st_d;
   fetch_desc_t       desc_q, desc_d;
   logic [3:0]        r_q, r_d;
   logic [3:0]        c_q, c_d;
   logic              push;
   logic              last_col, last_row;
   logic [SUM_W-1:0]  row_sum, col_sum;
   logic [BUF_AW-1:0] wr_addr;
   logic              pipe_vld, pipe_pending;
   logic [BUF_AW-1:0] pipe_waddr;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= ST_IDLE;
         desc_q <= '0;
         r_q    <= '0;
         c_q    <= '0;
      end else begin
         st_q   <= st_d;
         desc_q <= desc_d;
         r_q    <= r_d;
         c_q    <= c_d;
      end
   end

   assign last_col = (c_q == desc_q.cnt_col - 4'd1);
   assign last_row = (r_q == desc_q.cnt_row - 4'd1);

   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      st_d   = st_q;
      desc_d = desc_q;
      r_d    = r_q;
      c_d    = c_q;
      push   = 1'b0;
      unique case (st_q)
         ST_IDLE: begin
            if (start) begin
               desc_d = '{blk_row: blk_row, blk_col: blk_col,
                          cnt_row: cnt_row, cnt_col: cnt_col,
                          pad_row: pad_row, pad_col: pad_col};
               r_d    = '0;
               c_d    = '0;
               st_d   = (cnt_row == 4'd0 || cnt_col == 4'd0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (bus.mem_gnt) begin
               push = 1'b1;
               if (last_col) begin
                  c_d = '0;
                  r_d = r_q + 4'd1;
                  if (last_row) st_d = ST_DRAIN;
               end else begin
                  c_d = c_q + 4'd1;
               end
            end
         end
         // The output stage retires this cycle, so only earlier stages matter.
         ST_DRAIN: if (!pipe_pending) st_d = ST_DONE;
         ST_DONE:  st_d = ST_IDLE;
         default:  st_d = ST_IDLE;
      endcase
   end

   assign row_sum = SUM_W'(desc_q.blk_row) + SUM_W'(r_q);
   assign col_sum = SUM_W'(desc_q.blk_col) + SUM_W'(c_q);
   assign wr_addr = buf_addr(BUF_AW'(desc_q.pad_row) + BUF_AW'(r_q),
                             BUF_AW'(desc_q.pad_col) + BUF_AW'(c_q));

   assign busy         = (st_q != ST_IDLE);
   assign done         = (st_q == ST_DONE);
   assign bus.mem_req  = (st_q == ST_FETCH);
   assign bus.mem_addr = (st_q == ST_FETCH) ? frame_addr(row_sum, col_sum) : '0;

   fetch_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (push),
      .waddr_i   (wr_addr),
      .vld_o     (pipe_vld),
      .waddr_o   (pipe_waddr),
      .pending_o (pipe_pending)
   );

   assign bus.buf_we    = pipe_vld;
   assign bus.buf_waddr = pipe_waddr;
   assign bus.buf_wdata = pipe_vld ? bus.mem_rdata : '0;

   // Window and pad placement are the coordinate stage's responsibility.
   a_frame_rows: assert property (@(posedge clk) disable iff (!rst_n)
      (st_q == ST_IDLE && start) |-> (SUM_W'(blk_row) + SUM_W'(cnt_row) <= SUM_W'(FRAME_H)));
   a_frame_cols: assert property (@(posedge clk) disable iff (!rst_n)
      (st_q == ST_IDLE && start) |-> (SUM_W'(blk_col) + SUM_W'(cnt_col) <= SUM_W'(FRAME_W)));
   a_buf_rows: assert property (@(posedge clk) disable iff (!rst_n)
      (st_q == ST_IDLE && start) |-> (SUM_W'(pad_row) + SUM_W'(cnt_row) <= SUM_W'(BUF_W)));
   a_buf_cols: assert property (@(posedge clk) disable iff (!rst_n)
      (st_q == ST_IDLE && start) |-> (SUM_W'(pad_col) + SUM_W'(cnt_col) <= SUM_W'(BUF_W)));

endmodule

// File: tb/tb_block_fetch.sv
// Directed bench for block_fetch: one instance with RD_LAT=1 and one with
// RD_LAT=2 share stimulus; each has its own fixed-latency memory model.
module tb_block_fetch;
   import memc_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [5:0] blk_row, blk_col;
   logic [3:0] cnt_row, cnt_col, pad_row, pad_col;
   logic       gnt;
   logic       busy1, done1, busy2, done2;

   block_fetch_if bus1 ();
   block_fetch_if bus2 ();

   block_fetch #(.RD_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .blk_row(blk_row), .blk_col(blk_col), .cnt_row(cnt_row), .cnt_col(cnt_col),
      .pad_row(pad_row), .pad_col(pad_col), .busy(busy1), .done(done1), .bus(bus1)
   );

   block_fetch #(.RD_LAT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .blk_row(blk_row), .blk_col(blk_col), .cnt_row(cnt_row), .cnt_col(cnt_col),
      .pad_row(pad_row), .pad_col(pad_col), .busy(busy2), .done(done2), .bus(bus2)
   );

   always #5 clk = ~clk;

   function automatic logic [PIX_W-1:0] pix(input logic [MEM_AW-1:0] a);
      return a[7:0] ^ {a[11:8], a[11:8]};
   endfunction

   // Frame memory: pixel returned exactly RD_LAT cycles after an accept.
   logic [PIX_W-1:0] mp1;
   logic [PIX_W-1:0] mp2 [2];
   always @(posedge clk) begin
      mp1    <= (bus1.mem_req && bus1.mem_gnt) ? pix(bus1.mem_addr) : '0;
      mp2[0] <= (bus2.mem_req && bus2.mem_gnt) ? pix(bus2.mem_addr) : '0;
      mp2[1] <= mp2[0];
   end
   assign bus1.mem_rdata = mp1;
   assign bus2.mem_rdata = mp2[1];
   assign bus1.mem_gnt   = gnt;
   assign bus2.mem_gnt   = gnt;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   int acc_n, wr_n, wr2_n, req_n;
   int done_cyc, done2_cyc, last_acc_cyc;
   int first_acc, last_acc, max_acc, first_wr, last_wr;

   // Cycle 0 is the start cycle; outputs of cycle k are sampled at its negedge.
   task automatic run(input int br, input int bc, input int cr, input int cc,
                      input int pr, input int pc, input bit throttle,
                      input int restart_at, input int max_cyc);
      int          exp_a, exp_w;
      logic [11:0] prev_addr;
      bit          prev_stall;
      acc_n = 0; wr_n = 0; wr2_n = 0; req_n = 0;
      done_cyc = -1; done2_cyc = -1; last_acc_cyc = -1;
      first_acc = -1; last_acc = -1; max_acc = -1; first_wr = -1; last_wr = -1;
      prev_stall = 1'b0;
      prev_addr  = '0;
      @(negedge clk);
      start   = 1'b1;
      blk_row = 6'(br); blk_col = 6'(bc);
      cnt_row = 4'(cr); cnt_col = 4'(cc);
      pad_row = 4'(pr); pad_col = 4'(pc);
      gnt     = 1'b1;
      for (int k = 1; k <= max_cyc && (done_cyc < 0 || done2_cyc < 0); k++) begin
         @(negedge clk);
         start = (k == restart_at);
         if (k == restart_at) begin
            blk_row = 6'd0; blk_col = 6'd0; cnt_row = 4'd1; cnt_col = 4'd1;
         end
         gnt = throttle ? (k % 2 == 1) : 1'b1;
         check("busy", int'(busy1), int'(done_cyc < 0));
         if (bus1.mem_req) begin
            req_n++;
            if (prev_stall) check("addr_hold", int'(bus1.mem_addr), int'(prev_addr));
         end
         if (bus1.mem_req && gnt) begin
            exp_a = (br + acc_n / cc) * FRAME_W + bc + acc_n % cc;
            check("acc_addr", int'(bus1.mem_addr), exp_a);
            if (first_acc < 0) first_acc = int'(bus1.mem_addr);
            last_acc = int'(bus1.mem_addr);
            if (last_acc > max_acc) max_acc = last_acc;
            last_acc_cyc = k;
            acc_n++;
         end
         prev_stall = bus1.mem_req && !gnt;
         prev_addr  = bus1.mem_addr;
         if (bus1.buf_we) begin
            exp_w = (pr + wr_n / cc) * BUF_W + pc + wr_n % cc;
            exp_a = (br + wr_n / cc) * FRAME_W + bc + wr_n % cc;
            check("wr_addr", int'(bus1.buf_waddr), exp_w);
            check("wr_data", int'(bus1.buf_wdata), int'(pix(12'(exp_a))));
            if (first_wr < 0) first_wr = int'(bus1.buf_waddr);
            last_wr = int'(bus1.buf_waddr);
            wr_n++;
         end
         if (bus2.buf_we) begin
            exp_w = (pr + wr2_n / cc) * BUF_W + pc + wr2_n % cc;
            exp_a = (br + wr2_n / cc) * FRAME_W + bc + wr2_n % cc;
            check("wr2_addr", int'(bus2.buf_waddr), exp_w);
            check("wr2_data", int'(bus2.buf_wdata), int'(pix(12'(exp_a))));
            wr2_n++;
         end
         if (done1) begin
            if (done_cyc >= 0) check("done_pulse", k, done_cyc);
            else done_cyc = k;
         end
         if (done2 && done2_cyc < 0) done2_cyc = k;
      end
      @(negedge clk);
      check("idle_busy", int'(busy1), 0);
      check("idle_done", int'(done1), 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; gnt = 1'b0;
      blk_row = '0; blk_col = '0; cnt_row = '0; cnt_col = '0; pad_row = '0; pad_col = '0;
      #1;
      check("rst_busy",  int'(busy1), 0);
      check("rst_done",  int'(done1), 0);
      check("rst_req",   int'(bus1.mem_req), 0);
      check("rst_addr",  int'(bus1.mem_addr), 0);
      check("rst_we",    int'(bus1.buf_we), 0);
      check("rst_waddr", int'(bus1.buf_waddr), 0);
      check("rst_wdata", int'(bus1.buf_wdata), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // 8x8 window, unthrottled
      run(8, 16, 8, 8, 0, 0, 1'b0, -1, 200);
      check("b8_first_acc", first_acc, 528);
      check("b8_last_acc",  last_acc, 983);
      check("b8_first_wr",  first_wr, 0);
      check("b8_last_wr",   last_wr, 91);
      check("b8_acc_n",     acc_n, 64);
      check("b8_wr_n",      wr_n, 64);
      check("b8_done",      done_cyc, 66);
      check("b8_wr2_n",     wr2_n, 64);
      check("b8_done2",     done2_cyc, 67);

      // top-left clip with pad offset
      run(0, 0, 10, 10, 2, 2, 1'b0, -1, 200);
      check("tl_first_acc", first_acc, 0);
      check("tl_first_wr",  first_wr, 26);
      check("tl_last_acc",  last_acc, 585);
      check("tl_last_wr",   last_wr, 143);
      check("tl_wr_n",      wr_n, 100);
      check("tl_done",      done_cyc, 102);

      // bottom-right corner of the frame
      run(38, 54, 10, 10, 0, 0, 1'b0, -1, 200);
      check("br_last_acc", last_acc, 3071);
      check("br_max_acc",  max_acc, 3071);
      check("br_wr_n",     wr_n, 100);

      // grant toggling 1,0
      run(5, 7, 3, 4, 1, 1, 1'b1, -1, 200);
      check("gt_first_acc", first_acc, 327);
      check("gt_wr_n",      wr_n, 12);
      check("gt_last_cyc",  last_acc_cyc, 23);
      check("gt_done",      done_cyc, 25);
      check("gt_done_gap",  done_cyc - last_acc_cyc, 2);

      // zero-size window
      run(3, 3, 0, 4, 0, 0, 1'b0, -1, 20);
      check("z_done",  done_cyc, 1);
      check("z_done2", done2_cyc, 1);
      check("z_req_n", req_n, 0);
      check("z_wr_n",  wr_n, 0);

      // start pulse while fetching
      run(2, 3, 3, 4, 0, 0, 1'b0, 3, 200);
      check("rs_acc_n",    acc_n, 12);
      check("rs_wr_n",     wr_n, 12);
      check("rs_last_acc", last_acc, 262);
      check("rs_done",     done_cyc, 14);

      // reset with reads in flight on the RD_LAT=2 instance
      @(negedge clk);
      start = 1'b1; blk_row = 6'd0; blk_col = 6'd0;
      cnt_row = 4'd10; cnt_col = 4'd10; pad_row = 4'd0; pad_col = 4'd0; gnt = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("mr_pre_we2", int'(bus2.buf_we), 1);
      #2 rst_n = 1'b0;
      #1;
      check("mr_we1",   int'(bus1.buf_we), 0);
      check("mr_we2",   int'(bus2.buf_we), 0);
      check("mr_busy2", int'(busy2), 0);
      check("mr_req2",  int'(bus2.mem_req), 0);
      @(negedge clk);
      check("mr_we2_hold", int'(bus2.buf_we), 0);
      rst_n = 1'b1;
      run(8, 16, 8, 8, 0, 0, 1'b0, -1, 200);
      check("mr_wr_n",  wr_n, 64);
      check("mr_wr2_n", wr2_n, 64);
      check("mr_done",  done_cyc, 66);
      check("mr_done2", done2_cyc, 67);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
